timer_bank: RTL

- Parametrised successor to the two-instance system timer.
- One bus-mapped bank of N_CH independent down-counting timer channels.
- Each channel has a per-channel prescaler, one-shot and auto-reload modes, and a sticky write-1-to-clear interrupt status.
- Sits behind the Bridge on the DM bus; its IRQ vector feeds the HWInt bits of the CPU.

---
 rtl/tc_pkg.sv | 30 +++
 rtl/tc_channel.sv | 135 +++++++++++++
 rtl/timer_bank.sv | 90 +++++++++
 3 files changed

// File: rtl/tc_pkg.sv
// Shared constants and types for the timer bank: register map, CTRL layout,
// mode encodings and the per-channel state enum.
package tc_pkg;

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegPreset = 2'd1;
  localparam logic [1:0] RegCount  = 2'd2;
  localparam logic [1:0] RegStatus = 2'd3;

  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlModeLsb  = 1;
  localparam int unsigned CtrlImBit    = 3;
  localparam int unsigned CtrlPrescLsb = 8;

  localparam logic [1:0] ModeOneShot    = 2'b00;
  localparam logic [1:0] ModeAutoReload = 2'b01;

  // Channel index field is sized for the maximum of 8 channels so that
  // indices beyond N_CH decode as unmapped instead of aliasing.
  localparam int unsigned ChSelLsb = 4;
  localparam int unsigned ChSelW   = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCnt,
    StExpire
  } tc_state_e;

endpackage

// File: rtl/tc_channel.sv
// One down-counting timer channel: CTRL/PRESET/PEND registers, prescaler,
// counter and the IDLE/LOAD/CNT/EXPIRE sequencer.
module tc_channel
  import tc_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ctrl_we_i,
  input  logic               preset_we_i,
  input  logic               status_we_i,
  input  logic [31:0]        wdata_i,
  output logic               en_o,
  output logic [1:0]         mode_o,
  output logic               im_o,
  output logic [PRESC_W-1:0] presc_o,
  output logic [CNT_W-1:0]   preset_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               pend_o,
  output logic               irq_o
);

  tc_state_e          state_q, state_d;
  logic               en_q, en_d;
  logic [1:0]         mode_q, mode_d;
  logic               im_q, im_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] div_q, div_d;
  logic [CNT_W-1:0]   preset_q, preset_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pend_q, pend_d;

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    presc_d  = presc_q;
    div_d    = div_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;

    if (ctrl_we_i) begin
      en_d    = wdata_i[CtrlEnBit];
      mode_d  = wdata_i[CtrlModeLsb +: 2];
      im_d    = wdata_i[CtrlImBit];
      presc_d = wdata_i[CtrlPrescLsb +: PRESC_W];
    end
    if (preset_we_i) begin
      preset_d = wdata_i[CNT_W-1:0];
    end
    if (status_we_i && wdata_i[0]) begin
      pend_d = 1'b0;
    end

    unique case (state_q)
      // Start on the same edge that sets EN so COUNT shows PRESET one edge later.
      StIdle: begin
        if (en_d) state_d = StLoad;
      end
      StLoad: begin
        if (!en_q) begin
          state_d = StIdle;
        end else begin
          count_d = preset_q;
          div_d   = '0;
          state_d = StCnt;
        end
      end
      StCnt: begin
        if (!en_q) begin
          state_d = StIdle;
        end else if (div_q >= presc_q) begin
          div_d = '0;
          if (count_q <= CNT_W'(1)) begin
            count_d = '0;
            state_d = StExpire;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end else begin
          div_d = div_q + PRESC_W'(1);
        end
      end
      StExpire: begin
        // Set beats a same-edge W1C; a same-edge EN clear suppresses the reload.
        pend_d = 1'b1;
        if (en_d && (mode_d == ModeAutoReload)) begin
          state_d = StLoad;
        end else begin
          en_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      en_q     <= 1'b0;
      mode_q   <= ModeOneShot;
      im_q     <= 1'b0;
      presc_q  <= '0;
      div_q    <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      presc_q  <= presc_d;
      div_q    <= div_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  assign en_o     = en_q;
  assign mode_o   = mode_q;
  assign im_o     = im_q;
  assign presc_o  = presc_q;
  assign preset_o = preset_q;
  assign count_o  = count_q;
  assign pend_o   = pend_q;
  assign irq_o    = pend_q & im_q;

endmodule

// File: rtl/timer_bank.sv
// Bus-mapped bank of N_CH timer channels: address decode, read mux and the
// per-channel / combined interrupt outputs.
module timer_bank
  import tc_pkg::*;
#(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:2]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  output logic [N_CH-1:0] IRQ,
  output logic            IRQ_any
);

  logic [1:0]              reg_sel;
  logic [ChSelW-1:0]       ch_sel;
  logic [N_CH-1:0][31:0]   rd_words;
  logic                    unused_addr;

  assign reg_sel     = Addr[3:2];
  assign ch_sel      = Addr[ChSelLsb +: ChSelW];
  assign unused_addr = ^Addr[31:ChSelLsb+ChSelW];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic               hit;
    logic               en;
    logic [1:0]         mode;
    logic               im;
    logic [PRESC_W-1:0] presc;
    logic [CNT_W-1:0]   preset;
    logic [CNT_W-1:0]   count;
    logic               pend;
    logic [31:0]        rd_word;

    assign hit = (ch_sel == ChSelW'(i));

    tc_channel #(
      .CNT_W  (CNT_W),
      .PRESC_W(PRESC_W)
    ) u_ch (
      .clk_i      (clk),
      .rst_ni     (reset),
      .ctrl_we_i  (WE && hit && (reg_sel == RegCtrl)),
      .preset_we_i(WE && hit && (reg_sel == RegPreset)),
      .status_we_i(WE && hit && (reg_sel == RegStatus)),
      .wdata_i    (Din),
      .en_o       (en),
      .mode_o     (mode),
      .im_o       (im),
      .presc_o    (presc),
      .preset_o   (preset),
      .count_o    (count),
      .pend_o     (pend),
      .irq_o      (IRQ[i])
    );

    always_comb begin
      rd_word = '0;
      unique case (reg_sel)
        RegCtrl: begin
          rd_word[CtrlEnBit]                = en;
          rd_word[CtrlModeLsb +: 2]         = mode;
          rd_word[CtrlImBit]                = im;
          rd_word[CtrlPrescLsb +: PRESC_W]  = presc;
        end
        RegPreset: rd_word[CNT_W-1:0] = preset;
        RegCount:  rd_word[CNT_W-1:0] = count;
        default:   rd_word[0]         = pend;
      endcase
    end

    assign rd_words[i] = rd_word;
  end

  // Unmapped channel indices fall through to zero.
  always_comb begin
    Dout = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == ChSelW'(i)) Dout = rd_words[i];
    end
  end

  assign IRQ_any = |IRQ;

endmodule
